// File: rtl/bb_uart_txq.sv
// ---------------------------------------------------------------------------
// bb_uart_txq
//
// Transmit byte queue and sequencer sitting directly in front of the UART TX
// stage. Bytes from a producer are buffered in a small synchronous FIFO and
// handed to the TX stage one at a time over the txen/txreg/txbsy handshake.
// Everything runs on txbd_clk, so the producer must run on that clock too.
//
// Parameters
//   DEPTH    FIFO entries (power of two, 2..16)
//   AW       pointer width, log2(DEPTH); level is AW+1 bits
//   BSY_TMO  cycles allowed for txbsy to rise after a txen pulse (1..7)
//
// Ports
//   txbd_clk  in   1     baud clock, rising edge
//   rst       in   1     synchronous, active-high reset
//   wr_en     in   1     producer write strobe
//   wr_data   in   8     byte to enqueue
//   full      out  1     level == DEPTH
//   empty     out  1     level == 0
//   level     out  AW+1  bytes queued (the byte in flight is not counted)
//   txen      out  1     one-cycle start pulse to the TX stage
//   txreg     out  8     byte for the TX stage, held until the next load
//   txbsy     in   1     TX stage busy (start bit .. stop bit)
//   tmo       out  1     one-cycle pulse when the TX stage never went busy
//   ovf       out  1     (only with BB_TXQ_OVF_EN) sticky dropped-write flag
//
// Build option
//   BB_TXQ_OVF_EN  adds the ovf output. Without it, writes to a full queue are
//                  dropped silently and the port list has no ovf.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module bb_uart_txq #(
   parameter int DEPTH   = 4,
   parameter int AW      = 2,
   parameter int BSY_TMO = 3
) (
   input  logic          txbd_clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level,
   output logic          txen,
   output logic [7:0]    txreg,
   input  logic          txbsy,
   output logic          tmo
`ifdef BB_TXQ_OVF_EN
   ,
   output logic          ovf
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WBSY,
      S_WDONE
   } state_t;

   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
   // The LOAD cycle already counts as the first cycle of the busy wait, so the
   // WBSY counter gives up one step earlier than BSY_TMO-1.
   localparam logic [2:0]  TMO_LAST = (BSY_TMO >= 2) ? 3'(BSY_TMO - 2) : 3'd0;

   logic [7:0]  r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   state_t      r_state;
   logic [2:0]  r_cnt;
   logic        r_txen;
   logic        r_tmo;
   logic [7:0]  r_txreg;

   logic [AW:0] w_level;
   logic        w_full;
   logic        w_empty;
   logic        w_wr_acc;
   logic        w_pop;

   // Pointers carry one extra wrap bit, so the plain difference is the level.
   assign w_level  = r_wr_ptr - r_rd_ptr;
   assign w_full   = (w_level == LVL_FULL);
   assign w_empty  = (w_level == '0);
   // A write while full is dropped even if a pop happens on the same edge.
   assign w_wr_acc = wr_en && !w_full;
   // Never launch a byte into a TX stage that still reports busy.
   assign w_pop    = (r_state == S_IDLE) && !w_empty && !txbsy;

   assign full  = w_full;
   assign empty = w_empty;
   assign level = w_level;
   assign txen  = r_txen;
   assign txreg = r_txreg;
   assign tmo   = r_tmo;

   // FIFO storage: data only, no reset.
   always_ff @(posedge txbd_clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge txbd_clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge txbd_clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_txen  <= 1'b0;
         r_tmo   <= 1'b0;
         r_txreg <= 8'h00;
      end else begin
         r_txen <= 1'b0;
         r_tmo  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_txreg <= r_mem[r_rd_ptr[AW-1:0]];
                  r_txen  <= 1'b1;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_cnt   <= '0;
               r_state <= S_WBSY;
            end
            S_WBSY: begin
               if (txbsy) begin
                  r_state <= S_WDONE;
               end else if (r_cnt == TMO_LAST) begin
                  // TX stage never started: report it and drop the byte.
                  r_tmo   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            S_WDONE: begin
               // No timeout here: a full frame legitimately takes many cycles.
               if (!txbsy) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef BB_TXQ_OVF_EN
   logic r_ovf;

   always_ff @(posedge txbd_clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (wr_en && w_full) begin
         r_ovf <= 1'b1;
      end
   end

   assign ovf = r_ovf;
`endif

endmodule
